m6502_addr_sequencer: RTL and testbench

- Multi-cycle bus sequencer driven by the opcode decoder's operation/addressing-mode/access-type outputs.
- Generates the 6502 operand-fetch, effective-address and data read/write/RMW bus cycles for one instruction, then hands the operand or effective address to the execute stage.
- Sits between the decoder and the memory bus interface inside the M6502 core.

---
 rtl/m6502_addr_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_m6502_addr_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m6502_addr_sequencer.sv
// 6502 addressing-mode bus sequencer: operand fetch, effective-address resolution and the
// data read / write / read-modify-write cycles of one instruction.
package M6502Defs;
    typedef enum logic [3:0] {
        AddrMode_Implied,
        AddrMode_Immediate,
        AddrMode_ZeroPage,
        AddrMode_ZeroPageIndexed,
        AddrMode_Absolute,
        AddrMode_AbsoluteIndexed,
        AddrMode_IndexedIndirect,
        AddrMode_IndirectIndexed,
        AddrMode_AbsoluteIndirect,
        AddrMode_Relative
    } AddressingMode;

    typedef enum logic [1:0] {
        Access_Read,
        Access_Write,
        Access_ReadWrite
    } AccessType;
endpackage

module m6502_addr_sequencer
    import M6502Defs::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  AddressingMode     i_addressingMode,
    input  AccessType         i_accessType,
    input  logic              i_addressOnly,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_index,
    input  logic [DATA_W-1:0] i_dataIn,
    input  logic [DATA_W-1:0] i_storeData,
    input  logic [DATA_W-1:0] i_rmwResult,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_read,
    output logic              o_write,
    output logic [DATA_W-1:0] o_dataOut,
    output logic              o_pcIncrement,
    output logic [DATA_W-1:0] o_operand,
    output logic              o_operandValid,
    output logic [ADDR_W-1:0] o_effAddr,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned HI_W = ADDR_W - DATA_W;
    localparam logic [HI_W-1:0] PAGE_ZERO = '0;

    typedef enum logic [3:0] {
        StIdle,
        StOperLo,
        StOperHi,
        StZpDummy,
        StPtrLo,
        StPtrHi,
        StFixPage,
        StDataRd,
        StRmwDwr,
        StRmwWr,
        StDataWr
    } state_e;

    state_e            state_q, state_d;
    AddressingMode     mode_q, mode_d;
    AccessType         access_q, access_d;
    logic              addr_only_q, addr_only_d;
    logic              implied_q, implied_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [HI_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0] tgt_lo_q, tgt_lo_d;
    logic [HI_W-1:0]   base_hi_q, base_hi_d;
    logic [ADDR_W-1:0] eff_q, eff_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] rmw_q, rmw_d;

    logic              resolved;
    logic              indexed;
    logic              eff_load;
    logic [ADDR_W-1:0] eff_next;
    logic [DATA_W-1:0] zp_sum;

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        access_d      = access_q;
        addr_only_d   = addr_only_q;
        implied_d     = implied_q;
        pc_d          = pc_q;
        idx_d         = idx_q;
        store_d       = store_q;
        lo_d          = lo_q;
        hi_d          = hi_q;
        tgt_lo_d      = tgt_lo_q;
        base_hi_d     = base_hi_q;
        data_d        = data_q;
        rmw_d         = rmw_q;
        resolved      = 1'b0;
        indexed       = 1'b0;
        eff_load      = 1'b0;
        eff_next      = eff_q;
        zp_sum        = lo_q + idx_q;
        o_address     = '0;
        o_read        = 1'b0;
        o_write       = 1'b0;
        o_dataOut     = '0;
        o_pcIncrement = 1'b0;
        o_operandValid = 1'b0;
        o_done        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (implied_q) begin
                    // Implied/Relative: no bus traffic, just the completion pulse.
                    o_done    = 1'b1;
                    implied_d = 1'b0;
                end else if (i_start) begin
                    mode_d      = i_addressingMode;
                    access_d    = i_accessType;
                    addr_only_d = i_addressOnly;
                    pc_d        = i_pc;
                    idx_d       = i_index;
                    store_d     = i_storeData;
                    if (i_addressingMode == AddrMode_Implied ||
                        i_addressingMode == AddrMode_Relative) begin
                        implied_d = 1'b1;
                    end else begin
                        state_d = StOperLo;
                    end
                end
            end
            StOperLo: begin
                o_address     = pc_q;
                o_read        = 1'b1;
                o_pcIncrement = 1'b1;
                lo_d          = i_dataIn;
                case (mode_q)
                    AddrMode_Immediate: begin
                        o_operandValid = 1'b1;
                        o_done         = 1'b1;
                        state_d        = StIdle;
                    end
                    AddrMode_ZeroPage: begin
                        eff_next = {PAGE_ZERO, i_dataIn};
                        resolved = 1'b1;
                    end
                    AddrMode_ZeroPageIndexed, AddrMode_IndexedIndirect: state_d = StZpDummy;
                    AddrMode_Absolute, AddrMode_AbsoluteIndexed,
                    AddrMode_AbsoluteIndirect: state_d = StOperHi;
                    AddrMode_IndirectIndexed: begin
                        hi_d    = PAGE_ZERO;
                        state_d = StPtrLo;
                    end
                    default: state_d = StIdle;
                endcase
            end
            StOperHi: begin
                o_address     = pc_q + ADDR_W'(1);
                o_read        = 1'b1;
                o_pcIncrement = 1'b1;
                case (mode_q)
                    AddrMode_Absolute: begin
                        eff_next = {i_dataIn, lo_q};
                        resolved = 1'b1;
                    end
                    AddrMode_AbsoluteIndexed: begin
                        eff_next  = {i_dataIn, lo_q} + ADDR_W'(idx_q);
                        base_hi_d = i_dataIn;
                        indexed   = 1'b1;
                        resolved  = 1'b1;
                    end
                    default: begin
                        hi_d    = i_dataIn;
                        state_d = StPtrLo;
                    end
                endcase
            end
            StZpDummy: begin
                // Dummy read of the unindexed zero-page address while the index is added.
                o_address = {PAGE_ZERO, lo_q};
                o_read    = 1'b1;
                if (mode_q == AddrMode_IndexedIndirect) begin
                    lo_d    = zp_sum;
                    hi_d    = PAGE_ZERO;
                    state_d = StPtrLo;
                end else begin
                    eff_next = {PAGE_ZERO, zp_sum};
                    resolved = 1'b1;
                end
            end
            StPtrLo: begin
                o_address = {hi_q, lo_q};
                o_read    = 1'b1;
                tgt_lo_d  = i_dataIn;
                state_d   = StPtrHi;
            end
            StPtrHi: begin
                // Pointer high byte never carries into the next page (NMOS behaviour).
                o_address = {hi_q, lo_q + DATA_W'(1)};
                o_read    = 1'b1;
                resolved  = 1'b1;
                if (mode_q == AddrMode_IndirectIndexed) begin
                    eff_next  = {i_dataIn, tgt_lo_q} + ADDR_W'(idx_q);
                    base_hi_d = i_dataIn;
                    indexed   = 1'b1;
                end else begin
                    eff_next = {i_dataIn, tgt_lo_q};
                end
            end
            StFixPage: begin
                o_address = {base_hi_q, eff_q[DATA_W-1:0]};
                o_read    = 1'b1;
                state_d   = (access_q == Access_Write) ? StDataWr : StDataRd;
            end
            StDataRd: begin
                o_address      = eff_q;
                o_read         = 1'b1;
                o_operandValid = 1'b1;
                if (access_q == Access_ReadWrite) begin
                    data_d  = i_dataIn;
                    state_d = StRmwDwr;
                end else begin
                    o_done  = 1'b1;
                    state_d = StIdle;
                end
            end
            StRmwDwr: begin
                o_address = eff_q;
                o_write   = 1'b1;
                o_dataOut = data_q;
                rmw_d     = i_rmwResult;
                state_d   = StRmwWr;
            end
            StRmwWr: begin
                o_address = eff_q;
                o_write   = 1'b1;
                o_dataOut = rmw_q;
                o_done    = 1'b1;
                state_d   = StIdle;
            end
            StDataWr: begin
                o_address = eff_q;
                o_write   = 1'b1;
                o_dataOut = store_q;
                o_done    = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (resolved) begin
            eff_load = 1'b1;
            if (addr_only_q || mode_q == AddrMode_AbsoluteIndirect) begin
                o_done  = 1'b1;
                state_d = StIdle;
            end else if (indexed && (access_q != Access_Read ||
                                     eff_next[ADDR_W-1:DATA_W] != base_hi_d)) begin
                state_d = StFixPage;
            end else if (access_q == Access_Write) begin
                state_d = StDataWr;
            end else begin
                state_d = StDataRd;
            end
        end

        eff_d     = eff_load ? eff_next : eff_q;
        o_effAddr = eff_d;
        o_operand = o_operandValid ? i_dataIn : '0;
        o_busy    = (state_q != StIdle) || implied_q;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= StIdle;
            mode_q      <= AddrMode_Implied;
            access_q    <= Access_Read;
            addr_only_q <= 1'b0;
            implied_q   <= 1'b0;
            pc_q        <= '0;
            idx_q       <= '0;
            store_q     <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            tgt_lo_q    <= '0;
            base_hi_q   <= '0;
            eff_q       <= '0;
            data_q      <= '0;
            rmw_q       <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            access_q    <= access_d;
            addr_only_q <= addr_only_d;
            implied_q   <= implied_d;
            pc_q        <= pc_d;
            idx_q       <= idx_d;
            store_q     <= store_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            tgt_lo_q    <= tgt_lo_d;
            base_hi_q   <= base_hi_d;
            eff_q       <= eff_d;
            data_q      <= data_d;
            rmw_q       <= rmw_d;
        end
    end

endmodule

// File: tb/tb_m6502_addr_sequencer.sv
// Scoreboard bench: a cycle-list reference model fills a queue at issue time, a negedge
// monitor pops one expected bus cycle per active DUT cycle.
module tb_m6502_addr_sequencer;
    import M6502Defs::*;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    AddressingMode mode = AddrMode_Implied;
    AccessType     acc = Access_Read;
    logic          addr_only = 1'b0;
    logic [15:0]   pc = '0;
    logic [7:0]    idx = '0;
    logic [7:0]    store = '0;
    logic [7:0]    rmw = '0;
    logic [7:0]    din;
    logic [15:0]   address;
    logic          rd, wr;
    logic [7:0]    dout;
    logic          pcinc;
    logic [7:0]    operand;
    logic          opv;
    logic [15:0]   eff;
    logic          busy, done;

    logic [7:0] mem [0:65535];

    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        bit          pcinc;
        bit          opv;
        logic [7:0]  operand;
        bit          done;
        bit          chk_eff;
        logic [15:0] eff;
    } cyc_t;

    cyc_t exp_q[$];
    int   last_eff = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    m6502_addr_sequencer dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_start         (start),
        .i_addressingMode(mode),
        .i_accessType    (acc),
        .i_addressOnly   (addr_only),
        .i_pc            (pc),
        .i_index         (idx),
        .i_dataIn        (din),
        .i_storeData     (store),
        .i_rmwResult     (rmw),
        .o_address       (address),
        .o_read          (rd),
        .o_write         (wr),
        .o_dataOut       (dout),
        .o_pcIncrement   (pcinc),
        .o_operand       (operand),
        .o_operandValid  (opv),
        .o_effAddr       (eff),
        .o_busy          (busy),
        .o_done          (done)
    );

    assign din = mem[address];

    always #5 clk = ~clk;

    task automatic check(input string name, input bit ok, input string got, input string want);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, want %s", name, got, want);
    endtask

    function automatic cyc_t mk(input bit r, input bit w, input int a, input int wd, input bit pci,
                                input bit ov, input int opd);
        cyc_t c;
        c.rd = r; c.wr = w; c.addr = 16'(a); c.wdata = 8'(wd); c.pcinc = pci; c.opv = ov;
        c.operand = 8'(opd); c.done = 0; c.chk_eff = 0; c.eff = '0;
        return c;
    endfunction

    function automatic string fmt_out();
        return $sformatf("rd=%0b wr=%0b a=%h d=%h pci=%0b ov=%0b op=%h dn=%0b ea=%h bsy=%0b",
                         rd, wr, address, dout, pcinc, opv, operand, done, eff, busy);
    endfunction

    function automatic string fmt_exp(input cyc_t e);
        return $sformatf("rd=%0b wr=%0b a=%h d=%h pci=%0b ov=%0b op=%h dn=%0b ea=%h(chk=%0b)",
                         e.rd, e.wr, e.addr, e.wdata, e.pcinc, e.opv, e.operand, e.done,
                         e.eff, e.chk_eff);
    endfunction

    // Reference model: list every bus cycle the instruction must produce, straight from the
    // addressing-mode rules, using integer address arithmetic.
    task automatic model(input AddressingMode m, input AccessType a, input bit ao,
                         input int pcv, input int x, input int st, input int rm);
        cyc_t c[$];
        int op, lo, hi, base, ea, p, v;
        bit fix;
        fix = 0;
        ea = last_eff;
        base = 0;
        if (m == AddrMode_Implied || m == AddrMode_Relative) begin
            c.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        end else if (m == AddrMode_Immediate) begin
            c.push_back(mk(1, 0, pcv, 0, 1, 1, mem[pcv]));
        end else begin
            op = mem[pcv];
            c.push_back(mk(1, 0, pcv, 0, 1, 0, 0));
            case (m)
                AddrMode_ZeroPage: ea = op;
                AddrMode_ZeroPageIndexed: begin
                    c.push_back(mk(1, 0, op, 0, 0, 0, 0));
                    ea = (op + x) % 256;
                end
                AddrMode_IndexedIndirect: begin
                    c.push_back(mk(1, 0, op, 0, 0, 0, 0));
                    p = (op + x) % 256;
                    lo = mem[p];
                    c.push_back(mk(1, 0, p, 0, 0, 0, 0));
                    hi = mem[(p + 1) % 256];
                    c.push_back(mk(1, 0, (p + 1) % 256, 0, 0, 0, 0));
                    ea = hi * 256 + lo;
                end
                AddrMode_IndirectIndexed: begin
                    lo = mem[op];
                    c.push_back(mk(1, 0, op, 0, 0, 0, 0));
                    hi = mem[(op + 1) % 256];
                    c.push_back(mk(1, 0, (op + 1) % 256, 0, 0, 0, 0));
                    base = hi * 256 + lo;
                    ea = (base + x) % 65536;
                    fix = (a != Access_Read) || (ea / 256 != base / 256);
                end
                default: begin
                    hi = mem[(pcv + 1) % 65536];
                    c.push_back(mk(1, 0, (pcv + 1) % 65536, 0, 1, 0, 0));
                    base = hi * 256 + op;
                    if (m == AddrMode_Absolute) begin
                        ea = base;
                    end else if (m == AddrMode_AbsoluteIndexed) begin
                        ea = (base + x) % 65536;
                        fix = (a != Access_Read) || (ea / 256 != base / 256);
                    end else begin
                        lo = mem[base];
                        c.push_back(mk(1, 0, base, 0, 0, 0, 0));
                        p = (base / 256) * 256 + (base + 1) % 256;
                        hi = mem[p];
                        c.push_back(mk(1, 0, p, 0, 0, 0, 0));
                        ea = hi * 256 + lo;
                    end
                end
            endcase
            if (!ao && m != AddrMode_AbsoluteIndirect) begin
                if (fix) c.push_back(mk(1, 0, (base / 256) * 256 + ea % 256, 0, 0, 0, 0));
                v = mem[ea];
                if (a == Access_Write) begin
                    c.push_back(mk(0, 1, ea, st, 0, 0, 0));
                end else begin
                    c.push_back(mk(1, 0, ea, 0, 0, 1, v));
                    if (a == Access_ReadWrite) begin
                        c.push_back(mk(0, 1, ea, v, 0, 0, 0));
                        c.push_back(mk(0, 1, ea, rm, 0, 0, 0));
                    end
                end
            end
        end
        c[c.size() - 1].done = 1;
        c[c.size() - 1].chk_eff = (m != AddrMode_Immediate);
        c[c.size() - 1].eff = 16'(ea);
        if (m != AddrMode_Immediate) last_eff = ea;
        foreach (c[i]) exp_q.push_back(c[i]);
    endtask

    task automatic drive_start(input AddressingMode m, input AccessType a, input bit ao,
                               input logic [15:0] pcv, input logic [7:0] x, input logic [7:0] st,
                               input logic [7:0] rm);
        @(posedge clk);
        #1;
        mode = m; acc = a; addr_only = ao; pc = pcv; idx = x; store = st; rmw = rm;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic issue(input AddressingMode m, input AccessType a, input bit ao,
                         input logic [15:0] pcv, input logic [7:0] x, input logic [7:0] st,
                         input logic [7:0] rm);
        int n;
        model(m, a, ao, pcv, x, st, rm);
        drive_start(m, a, ao, pcv, x, st, rm);
        check("busy after accept", busy == 1'b1, $sformatf("%0b", busy), "1");
        n = 0;
        // Scramble latched inputs and poke i_start while busy; none of it may be accepted.
        while (busy && n < 40) begin
            start = 1'($urandom_range(0, 1));
            pc = 16'($urandom);
            idx = 8'($urandom);
            store = 8'($urandom);
            addr_only = 1'($urandom_range(0, 1));
            mode = AddressingMode'(4'($urandom_range(0, 9)));
            acc = AccessType'(2'($urandom_range(0, 2)));
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        if (n >= 40) begin
            check("instruction timeout", 1'b0, "still busy after 40 cycles", "done");
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin : monitor
        cyc_t e;
        bit ok;
        if (rd || wr || done) begin
            if (exp_q.size() == 0) begin
                check("unexpected cycle", 1'b0, fmt_out(), "no activity");
            end else begin
                e = exp_q.pop_front();
                ok = (rd == e.rd) && (wr == e.wr) && (pcinc == e.pcinc) && (opv == e.opv) &&
                     (done == e.done) && busy &&
                     (!(e.rd || e.wr) || address == e.addr) &&
                     (!e.wr || dout == e.wdata) &&
                     (!e.opv || operand == e.operand) &&
                     (!e.chk_eff || eff == e.eff);
                check("bus cycle", ok, fmt_out(), fmt_exp(e));
            end
        end
    end

    task automatic check_idle_zero(input string name);
        bit ok;
        ok = address == 16'h0000 && !rd && !wr && dout == 8'h00 && !pcinc && operand == 8'h00 &&
             !opv && eff == 16'h0000 && !busy && !done;
        check(name, ok, fmt_out(), "all zero");
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        AddressingMode m;
        AccessType a;
        bit ao;
        logic [15:0] pcv;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        rst = 1'b1;
        #12;
        check_idle_zero("reset state");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // LDA #$42
        mem[16'h8001] = 8'h42;
        issue(AddrMode_Immediate, Access_Read, 0, 16'h8001, 8'h00, 8'h00, 8'h00);
        // LDA $12F0,X with page cross, then without
        mem[16'h8001] = 8'hF0;
        mem[16'h8002] = 8'h12;
        issue(AddrMode_AbsoluteIndexed, Access_Read, 0, 16'h8001, 8'hFF, 8'h00, 8'h00);
        issue(AddrMode_AbsoluteIndexed, Access_Read, 0, 16'h8001, 8'h01, 8'h00, 8'h00);
        // STA ($F0),Y
        mem[16'h00F0] = 8'h00;
        mem[16'h00F1] = 8'h20;
        issue(AddrMode_IndirectIndexed, Access_Write, 0, 16'h8001, 8'h10, 8'hA5, 8'h00);
        // INC $80,X
        mem[16'h8001] = 8'h80;
        issue(AddrMode_ZeroPageIndexed, Access_ReadWrite, 0, 16'h8001, 8'h90, 8'h00, 8'h3C);
        // JMP ($10FF)
        mem[16'h8001] = 8'hFF;
        mem[16'h8002] = 8'h10;
        mem[16'h10FF] = 8'h34;
        mem[16'h1000] = 8'h12;
        mem[16'h1100] = 8'h56;
        issue(AddrMode_AbsoluteIndirect, Access_Read, 1, 16'h8001, 8'h00, 8'h00, 8'h00);
        check("effAddr holds", eff == 16'h1234, $sformatf("%h", eff), "1234");
        issue(AddrMode_Implied, Access_Read, 0, 16'h8003, 8'h00, 8'h00, 8'h00);

        // Reset in PTR_HI of ($20,X)
        mem[16'h8001] = 8'h20;
        model(AddrMode_IndexedIndirect, Access_Read, 0, 32'h8001, 4, 0, 0);
        drive_start(AddrMode_IndexedIndirect, Access_Read, 0, 16'h8001, 8'h04, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check("in PTR_HI before reset", rd && address == 16'h0025, fmt_out(), "rd a=0025");
        #1;
        rst = 1'b1;
        #1;
        check_idle_zero("async reset mid-instruction");
        exp_q.delete();
        last_eff = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(AddrMode_IndexedIndirect, Access_Read, 0, 16'h8001, 8'h04, 8'h00, 8'h00);

        for (int n = 0; n < 300; n++) begin
            m = AddressingMode'(4'($urandom_range(0, 9)));
            a = AccessType'(2'($urandom_range(0, 2)));
            ao = ($urandom_range(0, 7) == 0);
            if (m == AddrMode_AbsoluteIndirect) begin
                ao = 1;
                a = Access_Read;
            end
            if (m == AddrMode_Immediate) a = Access_Read;
            pcv = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            if ($urandom_range(0, 3) == 0) mem[16'(pcv + 16'd1)] = 8'hFF;
            issue(m, a, ao, pcv, 8'($urandom), 8'($urandom), 8'($urandom));
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard drained", exp_q.size() == 0, $sformatf("%0d left", exp_q.size()), "0 left");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
